// File: rtl/fp_sched_pkg.sv
// Shared types and constants for the floating-point adder scheduler.
package fp_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } sched_state_t;

  localparam int FP_W = 32;
  localparam logic [FP_W-1:0] FP_QNAN = 32'h7FC00000;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request above last_grant, wrapping.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      last_grant,
  output logic [NUM_REQ-1:0] grant,
  output logic [IW-1:0]      grant_idx
);

  logic              found;
  int unsigned       pos;
  logic [IW-1:0]     pos_idx;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    pos       = 0;
    pos_idx   = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      pos     = (32'(last_grant) + k) % 32'(NUM_REQ);
      pos_idx = IW'(pos);
      if (!found && req[pos_idx]) begin
        found          = 1'b1;
        grant[pos_idx] = 1'b1;
        grant_idx      = pos_idx;
      end
    end
  end

endmodule

// File: rtl/fp_add_scheduler.sv
// Round-robin scheduler sharing one start/done floating-point adder among
// NUM_REQ requesters, with one operation outstanding and a WAIT watchdog.
module fp_add_scheduler
  import fp_sched_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [32*NUM_REQ-1:0]   req_a,
  input  logic [32*NUM_REQ-1:0]   req_b,
  output logic [NUM_REQ-1:0]      req_ready,
  output logic [NUM_REQ-1:0]      rsp_valid,
  output logic [31:0]             rsp_data,
  output logic                    rsp_err,
  input  logic [NUM_REQ-1:0]      rsp_ready,
  output logic                    fpu_start,
  output logic [31:0]             fpu_a,
  output logic [31:0]             fpu_b,
  input  logic [31:0]             fpu_result,
  input  logic                    fpu_done
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  sched_state_t        state;
  logic [IW-1:0]       last_grant;
  logic [IW-1:0]       gnt_idx_q;
  logic [IW-1:0]       arb_idx;
  logic [NUM_REQ-1:0]  arb_grant;
  logic [7:0]          wd_cnt;
  logic [7:0]          wd_next;
  logic [FP_W-1:0]     a_q;
  logic [FP_W-1:0]     b_q;
  logic [FP_W-1:0]     sel_a;
  logic [FP_W-1:0]     sel_b;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IW      (IW)
  ) u_arb (
    .req        (req_valid),
    .last_grant (last_grant),
    .grant      (arb_grant),
    .grant_idx  (arb_idx)
  );

  // Grant is offered only while idle and out of reset; it is the accept itself.
  assign req_ready = (state == ST_IDLE && !rst) ? arb_grant : '0;
  assign fpu_a     = a_q;
  assign fpu_b     = b_q;
  assign wd_next   = wd_cnt + 8'd1;

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (arb_grant[i]) begin
        sel_a = req_a[i*FP_W +: FP_W];
        sel_b = req_b[i*FP_W +: FP_W];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      last_grant <= IW'(NUM_REQ - 1);
      gnt_idx_q  <= '0;
      a_q        <= '0;
      b_q        <= '0;
      rsp_data   <= '0;
      rsp_err    <= 1'b0;
      rsp_valid  <= '0;
      fpu_start  <= 1'b0;
      wd_cnt     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (|arb_grant) begin
            a_q       <= sel_a;
            b_q       <= sel_b;
            gnt_idx_q <= arb_idx;
            fpu_start <= 1'b1;
            state     <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          fpu_start <= 1'b0;
          wd_cnt    <= '0;
          state     <= ST_WAIT;
        end
        ST_WAIT: begin
          wd_cnt <= wd_next;
          // A done arriving on the expiry cycle still wins over the watchdog.
          if (fpu_done) begin
            rsp_data  <= fpu_result;
            rsp_err   <= 1'b0;
            rsp_valid <= NUM_REQ'(1) << gnt_idx_q;
            state     <= ST_RESP;
          end else if (wd_next == 8'(TIMEOUT)) begin
            rsp_data  <= FP_QNAN;
            rsp_err   <= 1'b1;
            rsp_valid <= NUM_REQ'(1) << gnt_idx_q;
            state     <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (rsp_ready[gnt_idx_q]) begin
            last_grant <= gnt_idx_q;
            rsp_valid  <= '0;
            state      <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_add_scheduler.sv
// Bench for fp_add_scheduler with a behavioural start/done adder stub.
module tb_fp_add_scheduler;

  localparam int N  = 4;
  localparam int TO = 16;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    req_valid = '0;
  logic [32*N-1:0] req_a = '0;
  logic [32*N-1:0] req_b = '0;
  logic [N-1:0]    req_ready;
  logic [N-1:0]    rsp_valid;
  logic [31:0]     rsp_data;
  logic            rsp_err;
  logic [N-1:0]    rsp_ready = '0;
  logic            fpu_start;
  logic [31:0]     fpu_a;
  logic [31:0]     fpu_b;
  logic [31:0]     fpu_result;
  logic            fpu_done;

  int              n_cmp = 0;
  int              n_bad = 0;
  int              model_last = N - 1;
  int unsigned     a_int [N];
  int unsigned     b_int [N];
  logic            hang = 1'b0;
  logic            inject = 1'b0;

  always #5 clk = ~clk;

  fp_add_scheduler #(.NUM_REQ(N), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err), .rsp_ready(rsp_ready),
    .fpu_start(fpu_start), .fpu_a(fpu_a), .fpu_b(fpu_b),
    .fpu_result(fpu_result), .fpu_done(fpu_done)
  );

  // Integer-valued IEEE single conversions (exact for values below 2^24).
  function automatic logic [31:0] i2f(input int unsigned n);
    int unsigned p;
    logic [31:0] m;
    if (n == 0) return '0;
    p = 0;
    for (int i = 0; i < 32; i++) if (n[i]) p = i;
    m = n << (23 - p);
    return {1'b0, 8'(127 + p), m[22:0]};
  endfunction

  function automatic int unsigned f2i(input logic [31:0] x);
    int e;
    logic [31:0] m;
    if (x[30:0] == '0) return 0;
    e = int'(x[30:23]) - 127;
    m = {8'b0, 1'b1, x[22:0]};
    return m >> (23 - e);
  endfunction

  // Adder stub: done four cycles after start; hang mode never completes.
  logic        adder_rst_n;
  int          st_cnt;
  logic        st_done;
  logic [31:0] st_res;
  assign adder_rst_n = ~rst;
  assign fpu_done    = st_done | inject;
  assign fpu_result  = st_res;

  always @(posedge clk or negedge adder_rst_n) begin
    if (!adder_rst_n) begin
      st_cnt  <= 0;
      st_done <= 1'b0;
      st_res  <= '0;
    end else begin
      st_done <= 1'b0;
      if (fpu_start) begin
        st_cnt <= 3;
        st_res <= i2f(f2i(fpu_a) + f2i(fpu_b));
      end else if (st_cnt != 0) begin
        st_cnt <= st_cnt - 1;
        if (st_cnt == 1 && !hang) st_done <= 1'b1;
      end
    end
  end

  function automatic int pick(input logic [N-1:0] v);
    int p;
    for (int k = 1; k <= N; k++) begin
      p = (model_last + k) % N;
      if (v[p]) return p;
    end
    return 0;
  endfunction

  task automatic load_operands();
    for (int i = 0; i < N; i++) begin
      a_int[i] = $urandom_range(1, (1 << 20) - 1);
      b_int[i] = $urandom_range(1, (1 << 20) - 1);
      req_a[32*i +: 32] = i2f(a_int[i]);
      req_b[32*i +: 32] = i2f(b_int[i]);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; req_valid = '0; rsp_ready = '0; inject = 1'b0; hang = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    model_last = N - 1;
  endtask

  // One full operation starting at a negedge in IDLE; fw/fd override the model when >=0 / nonzero.
  task automatic run_op(input logic [N-1:0] mask, input int stall, input bit hold,
                        input bit wd, input int fw, input logic [31:0] fd);
    int w;
    logic [N-1:0] oh;
    logic [31:0] exp_d;
    req_valid = mask;
    #1;
    w  = (fw >= 0) ? fw : pick(mask);
    oh = N'(1) << w;
    exp_d = (fd != 0) ? fd : i2f(a_int[w] + b_int[w]);
    n_cmp++;
    if (req_ready !== oh) begin
      n_bad++; $display("FAIL grant: req_ready=%b expected %b", req_ready, oh);
    end
    @(negedge clk);
    if (!hold) req_valid = '0;
    n_cmp++;
    if (fpu_start !== 1'b1 || fpu_a !== i2f(a_int[w]) || fpu_b !== i2f(b_int[w]) || req_ready !== '0) begin
      n_bad++;
      $display("FAIL issue: start=%b a=%h b=%h ready=%b expected 1 %h %h 0",
               fpu_start, fpu_a, fpu_b, req_ready, i2f(a_int[w]), i2f(b_int[w]));
    end
    for (int c = 2; c <= 5; c++) begin
      @(negedge clk);
      if (wd && c == 2) req_valid[1] = 1'b1;
      if (wd && c == 4) req_valid[1] = 1'b0;
      #1;
      n_cmp++;
      if ({rsp_valid, fpu_start, req_ready} !== '0) begin
        n_bad++; $display("FAIL busy c%0d: rsp_valid=%b start=%b ready=%b expected all 0",
                          c, rsp_valid, fpu_start, req_ready);
      end
    end
    @(negedge clk);
    n_cmp++;
    if (rsp_valid !== oh || rsp_data !== exp_d || rsp_err !== 1'b0) begin
      n_bad++; $display("FAIL response: valid=%b data=%h err=%b expected %b %h 0",
                        rsp_valid, rsp_data, rsp_err, oh, exp_d);
    end
    for (int s = 0; s < stall; s++) begin
      rsp_ready = N'($urandom) & ~oh;
      @(negedge clk);
      n_cmp++;
      if (rsp_valid !== oh || rsp_data !== exp_d || rsp_err !== 1'b0 || req_ready !== '0 || fpu_start !== 1'b0) begin
        n_bad++; $display("FAIL stall s%0d: valid=%b data=%h ready=%b start=%b expected %b %h 0 0",
                          s, rsp_valid, rsp_data, req_ready, fpu_start, oh, exp_d);
      end
    end
    rsp_ready = oh | N'($urandom);
    @(negedge clk);
    rsp_ready = '0;
    model_last = w;
    n_cmp++;
    if (rsp_valid !== '0) begin
      n_bad++; $display("FAIL release: rsp_valid=%b expected 0", rsp_valid);
    end
  endtask

  task automatic test_reset();
    req_valid = '1;
    @(negedge clk);
    n_cmp++;
    if (req_ready !== '0 || rsp_valid !== '0 || fpu_start !== 1'b0 || rsp_err !== 1'b0 ||
        rsp_data !== '0 || fpu_a !== '0 || fpu_b !== '0) begin
      n_bad++; $display("FAIL reset: ready=%b valid=%b start=%b err=%b data=%h a=%h b=%h expected all 0",
                        req_ready, rsp_valid, fpu_start, rsp_err, rsp_data, fpu_a, fpu_b);
    end
    do_reset();
  endtask

  task automatic test_single();
    load_operands();
    a_int[0] = 1; b_int[0] = 2;
    req_a[31:0] = 32'h3F800000;
    req_b[31:0] = 32'h40000000;
    run_op(4'b0001, 0, 1'b0, 1'b0, 0, 32'h40400000);
  endtask

  task automatic test_contention();
    do_reset();
    load_operands();
    run_op(4'b0101, 0, 1'b1, 1'b0, 0, 0);
    run_op(4'b0101, 0, 1'b1, 1'b0, 2, 0);
    do_reset();
    run_op(4'b1111, 0, 1'b1, 1'b0, 0, 0);
    run_op(4'b1111, 0, 1'b1, 1'b0, 1, 0);
    run_op(4'b1111, 0, 1'b1, 1'b0, 2, 0);
    run_op(4'b1111, 0, 1'b1, 1'b0, 3, 0);
    run_op(4'b1111, 0, 1'b1, 1'b0, 0, 0);
    req_valid = '0;
  endtask

  task automatic test_backpressure();
    load_operands();
    run_op(4'b0010, 10, 1'b0, 1'b0, 1, 0);
  endtask

  task automatic test_watchdog();
    logic [N-1:0] oh;
    int w;
    hang = 1'b1;
    load_operands();
    req_valid = 4'b0100;
    #1;
    w = pick(4'b0100);
    oh = N'(1) << w;
    n_cmp++;
    if (req_ready !== oh) begin
      n_bad++; $display("FAIL wd_grant: req_ready=%b expected %b", req_ready, oh);
    end
    @(negedge clk);
    req_valid = '0;
    n_cmp++;
    if (fpu_start !== 1'b1) begin
      n_bad++; $display("FAIL wd_issue: fpu_start=%b expected 1", fpu_start);
    end
    for (int c = 2; c <= TO + 1; c++) begin
      @(negedge clk);
      n_cmp++;
      if (rsp_valid !== '0) begin
        n_bad++; $display("FAIL wd_early c%0d: rsp_valid=%b expected 0", c, rsp_valid);
      end
    end
    @(negedge clk);
    n_cmp++;
    if (rsp_valid !== oh || rsp_data !== 32'h7FC00000 || rsp_err !== 1'b1) begin
      n_bad++; $display("FAIL wd_resp: valid=%b data=%h err=%b expected %b 7fc00000 1",
                        rsp_valid, rsp_data, rsp_err, oh);
    end
    rsp_ready = oh;
    @(negedge clk);
    rsp_ready = '0;
    model_last = w;
    hang = 1'b0;
    load_operands();
    run_op(4'b1000, 1, 1'b0, 1'b0, -1, 0);
  endtask

  task automatic test_reset_in_wait();
    req_valid = 4'b1000;
    @(negedge clk);
    req_valid = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    req_valid = '1;
    #1;
    n_cmp++;
    if (req_ready !== '0 || rsp_valid !== '0 || fpu_start !== 1'b0 || rsp_err !== 1'b0 ||
        rsp_data !== '0 || fpu_a !== '0 || fpu_b !== '0) begin
      n_bad++; $display("FAIL rst_wait: ready=%b valid=%b start=%b err=%b data=%h a=%h b=%h expected all 0",
                        req_ready, rsp_valid, fpu_start, rsp_err, rsp_data, fpu_a, fpu_b);
    end
    @(negedge clk);
    req_valid = '0;
    rst = 1'b0;
    model_last = N - 1;
    @(negedge clk);
    inject = 1'b1;
    @(negedge clk);
    inject = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      n_cmp++;
      if (rsp_valid !== '0 || fpu_start !== 1'b0) begin
        n_bad++; $display("FAIL stale_done c%0d: rsp_valid=%b start=%b expected 0 0", c, rsp_valid, fpu_start);
      end
    end
  endtask

  task automatic test_withdrawn();
    load_operands();
    run_op(4'b0001, 0, 1'b0, 1'b1, -1, 0);
    for (int c = 0; c < 8; c++) begin
      #1;
      n_cmp++;
      if (req_ready !== '0 || fpu_start !== 1'b0) begin
        n_bad++; $display("FAIL withdrawn c%0d: ready=%b start=%b expected 0 0", c, req_ready, fpu_start);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 30; it++) begin
      load_operands();
      run_op(N'($urandom_range(1, (1 << N) - 1)), $urandom_range(0, 3),
             1'($urandom_range(0, 1)), 1'b0, -1, 0);
    end
    req_valid = '0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_watchdog();
    test_reset_in_wait();
    test_withdrawn();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
